// File: rtl/tracking_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tracking_pkg
//  Purpose  : Shared widths, FSM state type and helpers for the multi-target
//             colour tracker.
//  Revision : 1.0 - initial release
// ============================================================================
package tracking_pkg;

  localparam int COORD_W = 12;
  localparam int COUNT_W = 20;
  localparam int RGB_W   = 24;

  typedef enum logic [0:0] {
    S_ACCUM  = 1'b0,
    S_REPORT = 1'b1
  } state_t;

  // Unsigned inclusive range test for one 8-bit colour channel
  function automatic logic in_range(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tracking_channel.sv
`default_nettype none
// ============================================================================
//  Module   : tracking_channel
//  Purpose  : One colour target: threshold latch, RGB window match, bounding
//             box / pixel-count accumulation and registered frame results.
//  Revision : 1.0 - initial release
// ============================================================================
module tracking_channel
  import tracking_pkg::*;
#(
  parameter int MIN_PIXELS = 16
) (
  input  logic               clock_50,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               first,
  input  logic               report,
  input  logic [RGB_W-1:0]   pixel,
  input  logic [RGB_W-1:0]   thr_lo,
  input  logic [RGB_W-1:0]   thr_hi,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               found,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] c_MIN_PIXELS = COUNT_W'(MIN_PIXELS);

  logic [RGB_W-1:0]   r_lo;
  logic [RGB_W-1:0]   r_hi;
  logic [COORD_W-1:0] r_min_x;
  logic [COORD_W-1:0] r_max_x;
  logic [COORD_W-1:0] r_min_y;
  logic [COORD_W-1:0] r_max_y;
  logic [COUNT_W-1:0] r_count;

  logic               r_found;
  logic [COORD_W-1:0] r_center_x;
  logic [COORD_W-1:0] r_center_y;
  logic [COORD_W-1:0] r_width;
  logic [COORD_W-1:0] r_height;
  logic [COUNT_W-1:0] r_count_out;

  logic [RGB_W-1:0]   w_lo;
  logic [RGB_W-1:0]   w_hi;
  logic               w_match;
  logic [COUNT_W-1:0] w_count_inc;
  logic [COORD_W:0]   w_sum_x;
  logic [COORD_W:0]   w_sum_y;
  logic               w_found;

  // The first pixel of a frame is judged against the live thresholds that are
  // being latched on that same edge; every later pixel uses the latched copy.
  assign w_lo = first ? thr_lo : r_lo;
  assign w_hi = first ? thr_hi : r_hi;

  assign w_match = in_range(pixel[23:16], w_lo[23:16], w_hi[23:16]) &&
                   in_range(pixel[15:8],  w_lo[15:8],  w_hi[15:8])  &&
                   in_range(pixel[7:0],   w_lo[7:0],   w_hi[7:0]);

  assign w_count_inc = (r_count == '1) ? r_count : r_count + COUNT_W'(1);

  // Centre sums carry an extra bit so (min+max)>>1 never overflows
  assign w_sum_x = {1'b0, r_min_x} + {1'b0, r_max_x};
  assign w_sum_y = {1'b0, r_min_y} + {1'b0, r_max_y};
  assign w_found = (r_count >= c_MIN_PIXELS);

  // Threshold latch and bounding-box / count accumulation
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_min_x <= '1;
      r_max_x <= '0;
      r_min_y <= '1;
      r_max_y <= '0;
      r_count <= '0;
    end else if (report) begin
      r_min_x <= '1;
      r_max_x <= '0;
      r_min_y <= '1;
      r_max_y <= '0;
      r_count <= '0;
    end else if (pix_en) begin
      if (first) begin
        // Start of frame: restart from this pixel alone
        r_lo <= thr_lo;
        r_hi <= thr_hi;
        if (w_match) begin
          r_min_x <= px;
          r_max_x <= px;
          r_min_y <= py;
          r_max_y <= py;
          r_count <= COUNT_W'(1);
        end else begin
          r_min_x <= '1;
          r_max_x <= '0;
          r_min_y <= '1;
          r_max_y <= '0;
          r_count <= '0;
        end
      end else if (w_match) begin
        if (px < r_min_x) r_min_x <= px;
        if (px > r_max_x) r_max_x <= px;
        if (py < r_min_y) r_min_y <= py;
        if (py > r_max_y) r_max_y <= py;
        r_count <= w_count_inc;
      end
    end
  end

  // Frame results, captured once per report and held until the next one
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_found     <= 1'b0;
      r_center_x  <= '0;
      r_center_y  <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_count_out <= '0;
    end else if (report) begin
      r_found     <= w_found;
      r_count_out <= r_count;
      if (w_found) begin
        r_center_x <= w_sum_x[COORD_W:1];
        r_center_y <= w_sum_y[COORD_W:1];
        r_width    <= r_max_x - r_min_x + COORD_W'(1);
        r_height   <= r_max_y - r_min_y + COORD_W'(1);
      end else begin
        r_center_x <= '0;
        r_center_y <= '0;
        r_width    <= '0;
        r_height   <= '0;
      end
    end
  end

  assign found    = r_found;
  assign center_x = r_center_x;
  assign center_y = r_center_y;
  assign width    = r_width;
  assign height   = r_height;
  assign count    = r_count_out;

endmodule
`default_nettype wire

// File: rtl/tracking_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tracking_multi
//  Purpose  : Raster-scan multi-target colour tracker. Owns the accept/report
//             FSM, raster counters and handshake; one tracking_channel per
//             target does the matching and box accumulation.
//  Revision : 1.0 - initial release
// ============================================================================
module tracking_multi
  import tracking_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_TARGETS = 2,
  parameter int MIN_PIXELS  = 16
) (
  input  logic                           clock_50,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [RGB_W-1:0]               in_data,
  input  logic                           in_sof,
  input  logic [NUM_TARGETS*RGB_W-1:0]   thr_lo,
  input  logic [NUM_TARGETS*RGB_W-1:0]   thr_hi,
  output logic                           out_valid,
  output logic [NUM_TARGETS-1:0]         found,
  output logic [NUM_TARGETS*COORD_W-1:0] center_x,
  output logic [NUM_TARGETS*COORD_W-1:0] center_y,
  output logic [NUM_TARGETS*COORD_W-1:0] width,
  output logic [NUM_TARGETS*COORD_W-1:0] height,
  output logic [NUM_TARGETS*COUNT_W-1:0] count
);

  localparam logic [COORD_W-1:0] c_X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] c_Y_LAST = COORD_W'(HEIGHT - 1);

  state_t             r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_report;
  logic               w_first;
  logic               w_last;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;
  logic [COORD_W-1:0] w_x_next;
  logic [COORD_W-1:0] w_y_next;

  assign in_ready  = (r_state == S_ACCUM);
  assign w_accept  = in_valid && in_ready;
  assign w_report  = (r_state == S_REPORT);
  assign out_valid = r_out_valid;

  // A start-of-frame marker re-homes the current pixel to (0,0)
  assign w_px    = in_sof ? '0 : r_x;
  assign w_py    = in_sof ? '0 : r_y;
  assign w_first = in_sof || ((r_x == '0) && (r_y == '0));
  assign w_last  = (w_px == c_X_LAST) && (w_py == c_Y_LAST);

  // Raster position following the pixel being accepted
  always_comb begin
    w_x_next = w_px + COORD_W'(1);
    w_y_next = w_py;
    if (w_px == c_X_LAST) begin
      w_x_next = '0;
      w_y_next = (w_py == c_Y_LAST) ? '0 : w_py + COORD_W'(1);
    end
  end

  // Accept/report FSM with raster counters; out_valid follows the report cycle
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_ACCUM;
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_report;
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            if (w_last) r_state <= S_REPORT;
          end
        end
        S_REPORT: r_state <= S_ACCUM;
        default:  r_state <= S_ACCUM;
      endcase
    end
  end

  generate
    for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_target
      tracking_channel #(
        .MIN_PIXELS(MIN_PIXELS)
      ) u_channel (
        .clock_50 (clock_50),
        .reset    (reset),
        .pix_en   (w_accept),
        .first    (w_first),
        .report   (w_report),
        .pixel    (in_data),
        .thr_lo   (thr_lo[k*RGB_W +: RGB_W]),
        .thr_hi   (thr_hi[k*RGB_W +: RGB_W]),
        .px       (w_px),
        .py       (w_py),
        .found    (found[k]),
        .center_x (center_x[k*COORD_W +: COORD_W]),
        .center_y (center_y[k*COORD_W +: COORD_W]),
        .width    (width[k*COORD_W +: COORD_W]),
        .height   (height[k*COORD_W +: COORD_W]),
        .count    (count[k*COUNT_W +: COUNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tracking_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tracking_multi
//  Purpose  : Directed self-checking bench for tracking_multi on an 8x4 frame
//             with a green target and a red target.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tracking_multi;

  localparam logic [23:0] c_GREEN    = 24'h10C010;
  localparam logic [23:0] c_BG       = 24'h404040;
  localparam logic [47:0] c_THR_LO   = {24'h800000, 24'h008000};
  localparam logic [47:0] c_THR_HI   = {24'hFF4040, 24'h32FF32};

  logic        clock_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data  = '0;
  logic        in_sof   = 1'b0;
  logic [47:0] thr_lo   = c_THR_LO;
  logic [47:0] thr_hi   = c_THR_HI;

  logic        in_ready,  in_ready_b;
  logic        out_valid, out_valid_b;
  logic [1:0]  found,     found_b;
  logic [23:0] center_x,  center_x_b;
  logic [23:0] center_y,  center_y_b;
  logic [23:0] width,     width_b;
  logic [23:0] height,    height_b;
  logic [39:0] count,     count_b;

  int n_cmp   = 0;
  int n_bad   = 0;
  int ov_cnt  = 0;
  int stalls  = 0;

  logic [1:0]  s_found [32];
  logic [23:0] s_cx    [32];
  logic [23:0] s_cy    [32];
  logic [23:0] s_w     [32];
  logic [23:0] s_h     [32];
  logic [39:0] s_cnt   [32];

  always #10 clock_50 = ~clock_50;

  tracking_multi #(.WIDTH(8), .HEIGHT(4), .NUM_TARGETS(2), .MIN_PIXELS(4)) dut_a (
    .clock_50(clock_50), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .out_valid(out_valid), .found(found), .center_x(center_x),
    .center_y(center_y), .width(width), .height(height), .count(count)
  );

  tracking_multi #(.WIDTH(8), .HEIGHT(4), .NUM_TARGETS(2), .MIN_PIXELS(1)) dut_b (
    .clock_50(clock_50), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_sof(in_sof), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .out_valid(out_valid_b), .found(found_b), .center_x(center_x_b),
    .center_y(center_y_b), .width(width_b), .height(height_b), .count(count_b)
  );

  // Snapshot every report pulse of the main instance
  always @(negedge clock_50) begin
    if (out_valid) begin
      s_found[ov_cnt % 32] = found;
      s_cx[ov_cnt % 32]    = center_x;
      s_cy[ov_cnt % 32]    = center_y;
      s_w[ov_cnt % 32]     = width;
      s_h[ov_cnt % 32]     = height;
      s_cnt[ov_cnt % 32]   = count;
      ov_cnt = ov_cnt + 1;
    end
  end

  function automatic logic [23:0] pat_a(input int x, input int y);
    return (x >= 2 && x <= 5 && y >= 1 && y <= 2) ? c_GREEN : c_BG;
  endfunction

  function automatic logic [23:0] pat_single(input int x, input int y);
    return (x == 7 && y == 3) ? c_GREEN : c_BG;
  endfunction

  task automatic send(input logic [23:0] pix, input logic sof);
    int guard = 0;
    @(negedge clock_50);
    in_valid = 1'b1;
    in_data  = pix;
    in_sof   = sof;
    while (!in_ready && guard < 20) begin
      stalls = stalls + 1;
      @(negedge clock_50);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clock_50);
    #1;
  endtask

  task automatic send_frame(input int kind, input bit gaps, input bit glitch);
    for (int idx = 0; idx < 32; idx++) begin
      if (gaps && idx != 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clock_50);
          in_valid = 1'b0;
          in_data  = 24'($urandom);
        end
      end
      send(kind == 0 ? pat_a(idx % 8, idx / 8) : pat_single(idx % 8, idx / 8), 1'b0);
      if (glitch && idx == 0) begin
        thr_lo = {24'h000000, 24'hFFFFFF};
        thr_hi = {24'hFFFFFF, 24'h000000};
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock_50);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int target);
    int guard = 0;
    while (ov_cnt < target && guard < 50) begin
      @(negedge clock_50);
      guard++;
    end
    @(negedge clock_50);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock_50);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (found !== 2'b00) begin n_bad++; $display("FAIL rst_found: got %0b want 0", found); end
    n_cmp++; if (count !== 40'd0) begin n_bad++; $display("FAIL rst_count: got %h want 0", count); end
    n_cmp++; if (center_x !== 24'd0 || width !== 24'd0) begin
      n_bad++; $display("FAIL rst_box: cx=%h w=%h want 0", center_x, width); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    int base = ov_cnt;
    send_frame(0, 1'b0, 1'b0);
    @(negedge clock_50);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_report_cycle: rdy=%0b ov=%0b want 0 0", in_ready, out_valid); end
    @(negedge clock_50);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_latency: ov=%0b rdy=%0b want 1 1", out_valid, in_ready); end
    @(negedge clock_50);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: ov=%0b want 0", out_valid); end
    n_cmp++; if (ov_cnt - base !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", ov_cnt - base); end
    n_cmp++; if (found !== 2'b01) begin n_bad++; $display("FAIL basic_found: got %b want 01", found); end
    n_cmp++; if (center_x !== 24'h000003 || center_y !== 24'h000001) begin
      n_bad++; $display("FAIL basic_center: cx=%h cy=%h want 000003 000001", center_x, center_y); end
    n_cmp++; if (width !== 24'h000004 || height !== 24'h000002) begin
      n_bad++; $display("FAIL basic_size: w=%h h=%h want 000004 000002", width, height); end
    n_cmp++; if (count !== 40'h0000000008) begin n_bad++; $display("FAIL basic_count: got %h want 0000000008", count); end
  endtask

  task automatic test_threshold_latch;
    int base = ov_cnt;
    send_frame(0, 1'b0, 1'b1);
    idle(1);
    wait_pulse(base + 1);
    thr_lo = c_THR_LO;
    thr_hi = c_THR_HI;
    n_cmp++; if (ov_cnt - base !== 1) begin n_bad++; $display("FAIL latch_pulses: got %0d want 1", ov_cnt - base); end
    n_cmp++; if (found !== 2'b01 || count !== 40'h0000000008) begin
      n_bad++; $display("FAIL latch_result: found=%b cnt=%h want 01 0000000008", found, count); end
    n_cmp++; if (center_x !== 24'h000003 || width !== 24'h000004) begin
      n_bad++; $display("FAIL latch_box: cx=%h w=%h want 000003 000004", center_x, width); end
  endtask

  task automatic test_back_to_back;
    int base = ov_cnt;
    int st0  = stalls;
    for (int f = 0; f < 4; f++) send_frame(0, 1'b1, 1'b0);
    idle(1);
    wait_pulse(base + 4);
    n_cmp++; if (ov_cnt - base !== 4) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 4", ov_cnt - base); end
    n_cmp++; if (stalls - st0 !== 3) begin n_bad++; $display("FAIL b2b_stalls: got %0d want 3", stalls - st0); end
    for (int i = 0; i < 4; i++) begin
      int j = (base + i) % 32;
      n_cmp++;
      if (s_found[j] !== 2'b01 || s_cx[j] !== 24'h000003 || s_cy[j] !== 24'h000001 ||
          s_w[j] !== 24'h000004 || s_h[j] !== 24'h000002 || s_cnt[j] !== 40'h0000000008) begin
        n_bad++;
        $display("FAIL b2b_frame%0d: found=%b cx=%h cy=%h w=%h h=%h cnt=%h want 01 3 1 4 2 8",
                 i, s_found[j], s_cx[j], s_cy[j], s_w[j], s_h[j], s_cnt[j]);
      end
    end
  endtask

  task automatic test_sof;
    int base = ov_cnt;
    for (int idx = 0; idx < 21; idx++) send(pat_a(idx % 8, idx / 8), 1'b0);
    // pixel (5,2) of the interrupted frame carries the marker
    send(c_GREEN, 1'b1);
    for (int idx = 1; idx < 32; idx++) begin
      send((idx == 1 || idx == 30 || idx == 31) ? c_GREEN : c_BG, 1'b0);
    end
    idle(6);
    n_cmp++; if (ov_cnt - base !== 1) begin n_bad++; $display("FAIL sof_pulses: got %0d want 1", ov_cnt - base); end
    n_cmp++; if (found !== 2'b01 || count !== 40'h0000000004) begin
      n_bad++; $display("FAIL sof_count: found=%b cnt=%h want 01 0000000004", found, count); end
    n_cmp++; if (center_x !== 24'h000003 || center_y !== 24'h000001) begin
      n_bad++; $display("FAIL sof_center: cx=%h cy=%h want 000003 000001", center_x, center_y); end
    n_cmp++; if (width !== 24'h000008 || height !== 24'h000004) begin
      n_bad++; $display("FAIL sof_size: w=%h h=%h want 000008 000004", width, height); end
  endtask

  task automatic test_reset_mid;
    int base;
    for (int idx = 0; idx < 27; idx++) send(pat_a(idx % 8, idx / 8), 1'b0);
    @(negedge clock_50);
    in_valid = 1'b1;
    in_data  = c_BG;
    reset    = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || found !== 2'b00 || count !== 40'd0) begin
      n_bad++; $display("FAIL rstmid_outputs: ov=%0b found=%b cnt=%h want 0", out_valid, found, count); end
    n_cmp++; if (center_x !== 24'd0 || height !== 24'd0) begin
      n_bad++; $display("FAIL rstmid_box: cx=%h h=%h want 0", center_x, height); end
    repeat (2) @(negedge clock_50);
    in_valid = 1'b0;
    reset    = 1'b1;
    idle(2);
    base = ov_cnt;
    send_frame(0, 1'b0, 1'b0);
    idle(6);
    n_cmp++; if (ov_cnt - base !== 1) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 1", ov_cnt - base); end
    n_cmp++; if (found !== 2'b01 || count !== 40'h0000000008 || center_x !== 24'h000003 ||
                 center_y !== 24'h000001 || width !== 24'h000004 || height !== 24'h000002) begin
      n_bad++; $display("FAIL rstmid_result: found=%b cnt=%h cx=%h cy=%h w=%h h=%h want 01 8 3 1 4 2",
                        found, count, center_x, center_y, width, height); end
  endtask

  task automatic test_single;
    int base = ov_cnt;
    send_frame(1, 1'b0, 1'b0);
    idle(1);
    wait_pulse(base + 1);
    n_cmp++; if (found_b !== 2'b01 || count_b !== 40'h0000000001) begin
      n_bad++; $display("FAIL single_found: found=%b cnt=%h want 01 0000000001", found_b, count_b); end
    n_cmp++; if (center_x_b !== 24'h000007 || center_y_b !== 24'h000003) begin
      n_bad++; $display("FAIL single_center: cx=%h cy=%h want 000007 000003", center_x_b, center_y_b); end
    n_cmp++; if (width_b !== 24'h000001 || height_b !== 24'h000001) begin
      n_bad++; $display("FAIL single_size: w=%h h=%h want 000001 000001", width_b, height_b); end
    n_cmp++; if (found !== 2'b00 || count !== 40'h0000000001) begin
      n_bad++; $display("FAIL single_below_min: found=%b cnt=%h want 00 0000000001", found, count); end
    n_cmp++; if (center_x !== 24'd0 || center_y !== 24'd0 || width !== 24'd0 || height !== 24'd0) begin
      n_bad++; $display("FAIL single_zeroed: cx=%h cy=%h w=%h h=%h want 0", center_x, center_y, width, height); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_threshold_latch;
    test_back_to_back;
    test_sof;
    test_reset_mid;
    test_single;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tracking_multi.md
TRACKING_MULTI -- requirements
Module: tracking_multi

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter NUM_TARGETS, default 2, number of independent colour trackers.
REQ-004 Parameter MIN_PIXELS, default 16, minimum matching pixels for a target to be reported found.
REQ-005 clock_50  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low.
REQ-007 in_valid  input  1  pixel present on in_data.
REQ-008 in_ready  output  1  block accepts pixel this cycle.
REQ-009 in_data  input  24  pixel, R[23:16] G[15:8] B[7:0].
REQ-010 in_sof  input  1  qualifies in_data as first pixel of a frame.
REQ-011 thr_lo  input  NUM_TARGETS*24  per-target inclusive lower RGB bounds, target k at [24k+23:24k].
REQ-012 thr_hi  input  NUM_TARGETS*24  per-target inclusive upper RGB bounds, same packing.
REQ-013 out_valid  output  1  one-cycle pulse, results valid.
REQ-014 found  output  NUM_TARGETS  per-target found flag.
REQ-015 center_x, center_y  output  NUM_TARGETS*12 each  box centre.
REQ-016 width, height  output  NUM_TARGETS*12 each  box size.
REQ-017 count  output  NUM_TARGETS*20  matching pixels per target.

Function
REQ-018 Handshake: pixel accepted iff in_valid && in_ready on a clock edge; in_ready SHALL be 1 in S_ACCUM, 0 in S_REPORT.
REQ-019 States S_ACCUM, S_REPORT; S_ACCUM -> S_REPORT on acceptance of pixel (WIDTH-1, HEIGHT-1); S_REPORT -> S_ACCUM unconditionally after one cycle.
REQ-020 Raster counters x, y (12 bit): x increments per accepted pixel, wraps to 0 at WIDTH-1 with y increment; y wraps to 0 after HEIGHT-1.
REQ-021 Pixel matches target k iff thr_lo_k <= channel <= thr_hi_k for all of R, G, B (unsigned, inclusive).
REQ-022 Thresholds SHALL be latched on acceptance of pixel (0,0) and held for the frame; mid-frame threshold changes have no effect until next frame.
REQ-023 Per target, on match: min_x, max_x, min_y, max_y updated by min/max; count incremented, saturating at 2^20-1.
REQ-024 In S_REPORT: out_valid=1 for exactly that cycle; outputs registered same edge and held until next report.
REQ-025 found_k = count_k >= MIN_PIXELS.
REQ-026 If found_k: center = (min+max)>>1 computed in 13 bits; width = max_x-min_x+1; height = max_y-min_y+1; else center, width, height = 0, count still reported.
REQ-027 Accumulators SHALL clear in S_REPORT (min to 12'hFFF, max to 0, count to 0) so the next frame starts clean.
REQ-028 in_sof accepted at any position: coordinates forced so that pixel is (0,0), accumulators cleared then updated with that pixel, thresholds latched; partial frame discarded, no report.
REQ-029 in_sof with (x,y)=(0,0) already: treated as normal first pixel, no discard.
REQ-030 Single-pixel match: min=max, width=height=1.
REQ-031 Latency: out_valid asserted on the edge after the last pixel is accepted.

Reset
REQ-032 On reset low: state S_ACCUM, x=y=0, out_valid=0, found=0, center_x, center_y, width, height, count = 0, accumulators cleared per REQ-027, latched thresholds = 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; no out_valid until a full frame follows.

Structure
REQ-034 Package tracking_pkg SHALL hold the state typedef, COORD_W=12, COUNT_W=20, RGB_W=24.
REQ-035 Per-target match/accumulate/result logic SHALL be sub-module tracking_channel, instantiated NUM_TARGETS times by generate; top holds FSM, counters, handshake.

Verification
REQ-036 WIDTH=8, HEIGHT=4, target0 lo=00_80_00 hi=32_FF_32, green pixels at x2..5,y1..2 (8 px), MIN_PIXELS=4 -> found0=1, center (3,1), width 4, height 2, count 8.
REQ-037 Same frame, target1 red bounds, no red pixels -> found1=0, all target1 results 0, count1 0.
REQ-038 in_valid toggled randomly and 3 pixels presented during S_REPORT -> in_ready=0 there, no pixel lost, results identical to REQ-036.
REQ-039 in_sof pulsed at pixel (5,2) of frame 1 with matches before it -> no report for frame 1; next full frame reports only post-sof pixels.
REQ-040 Reset asserted at pixel (3,3), then clean frame -> outputs 0 during reset, single out_valid after clean frame, correct results.
REQ-041 Single matching pixel at (7,3), MIN_PIXELS=1 -> center (7,3), width 1, height 1, count 1.
